// File: rtl/boundary_cardinality_scanner.sv
// Walks one boundary column of the decoding lattice, follows each touching PU to its cluster root and
// reports the parity (and, with BOUNDARY_CARDINALITY_COUNT_EN, the number) of distinct odd roots reached.
module boundary_cardinality_scanner #(
  parameter int CODE_DISTANCE_X = 4,
  parameter int CODE_DISTANCE_Z = 12,
  parameter int LANES           = 2,
  parameter int BOUNDARY_TYPE   = 0,
  localparam int ROUNDS   = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z,
  localparam int PU_COUNT = CODE_DISTANCE_X * CODE_DISTANCE_Z * ROUNDS,
  localparam int AW       = $clog2(PU_COUNT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   go,
  input  logic [PU_COUNT-1:0]    is_touching_boundaries,
  input  logic [PU_COUNT-1:0]    is_odd_cardinalities,
  input  logic [AW*PU_COUNT-1:0] roots,
  output logic                   busy,
  output logic                   done,
  output logic                   final_cardinality,
  output logic [AW:0]            odd_root_count,
  output logic                   root_error
);

  localparam int BPC    = CODE_DISTANCE_X * ROUNDS;
  localparam int GROUPS = (BPC + LANES - 1) / LANES;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int BJ     = (BOUNDARY_TYPE != 0) ? CODE_DISTANCE_Z - 1 : 0;

  // Boundary PU linear indices in visiting order (i fastest, then k), fixed at elaboration.
  function automatic logic [BPC*AW-1:0] build_map();
    logic [BPC*AW-1:0] m;
    m = '0;
    for (int n = 0; n < BPC; n++) begin
      m[AW*n +: AW] = AW'((n % CODE_DISTANCE_X) * CODE_DISTANCE_Z + BJ +
                          (n / CODE_DISTANCE_X) * CODE_DISTANCE_Z * CODE_DISTANCE_X);
    end
    return m;
  endfunction

  localparam logic [BPC*AW-1:0] BOUNDARY_MAP = build_map();

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       grp_q;
  logic                drain_q;
  logic                accept;

  logic [LANES-1:0][AW-1:0] lane_pu;
  logic [LANES-1:0]         lane_ok;
  logic [LANES-1:0][AW-1:0] s1_pu;
  logic [LANES-1:0]         s1_ok;

  logic [PU_COUNT-1:0] visited_q, visited_d;
  logic                parity_q, parity_d;
  logic                err_q, err_d;
  logic [AW-1:0]       lane_root;

  assign accept = (state_q == IDLE) && go;

  // NOTE: next-state logic is combinational with every output defaulted first, so no latch can form.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (go) state_d = SCAN;
      SCAN:  if (grp_q == GW'(GROUPS - 1)) state_d = DRAIN;
      DRAIN: if (drain_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grp_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept)                grp_q <= '0;
      else if (state_q == SCAN)  grp_q <= grp_q + 1'b1;
      drain_q <= (state_q == DRAIN) ? ~drain_q : 1'b0;
    end
  end

  // Stage 1: select this group's PU indices; lanes past the last boundary PU are masked.
  always_comb begin
    lane_pu = '0;
    lane_ok = '0;
    for (int l = 0; l < LANES; l++) begin
      if (int'(grp_q) * LANES + l < BPC) begin
        lane_ok[l] = 1'b1;
        lane_pu[l] = BOUNDARY_MAP[AW*(int'(grp_q) * LANES + l) +: AW];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_pu <= '0;
      s1_ok <= '0;
    end else begin
      s1_pu <= lane_pu;
      s1_ok <= (state_q == SCAN) ? lane_ok : '0;
    end
  end

`ifdef BOUNDARY_CARDINALITY_COUNT_EN
  logic [AW:0] count_q, count_d;
`endif

  // Stage 2: lanes are resolved in ascending order against a running bitmap, so the lowest lane
  // claims a root shared by several lanes in the same cycle.
  always_comb begin
    visited_d = visited_q;
    parity_d  = parity_q;
    err_d     = err_q;
    lane_root = '0;
`ifdef BOUNDARY_CARDINALITY_COUNT_EN
    count_d   = count_q;
`endif
    for (int l = 0; l < LANES; l++) begin
      if (s1_ok[l] && is_touching_boundaries[s1_pu[l]]) begin
        lane_root = roots[AW*int'(s1_pu[l]) +: AW];
        if (int'(lane_root) >= PU_COUNT) begin
          err_d = 1'b1;
        end else if (!visited_d[lane_root] && is_odd_cardinalities[lane_root]) begin
          visited_d[lane_root] = 1'b1;
          parity_d             = ~parity_d;
`ifdef BOUNDARY_CARDINALITY_COUNT_EN
          count_d              = count_d + 1'b1;
`endif
        end
      end
    end
  end

  // NOTE: the visited bitmap is a plain flop vector with an explicit reset, since a mid-scan reset must clear it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      visited_q <= '0;
      parity_q  <= 1'b0;
      err_q     <= 1'b0;
    end else if (accept) begin
      visited_q <= '0;
      parity_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      visited_q <= visited_d;
      parity_q  <= parity_d;
      err_q     <= err_d;
    end
  end

`ifdef BOUNDARY_CARDINALITY_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       count_q <= '0;
    else if (accept) count_q <= '0;
    else             count_q <= count_d;
  end
  assign odd_root_count = count_q;
`else
  assign odd_root_count = '0;
`endif

  assign busy              = (state_q == SCAN) || (state_q == DRAIN);
  assign done              = (state_q == DONE);
  assign final_cardinality = parity_q;
  assign root_error        = err_q;

endmodule

// File: tb/tb_boundary_cardinality_scanner.sv
// Self-checking bench: four 3x3x3 scanners (lanes 2/1/4 on boundary j=0, lanes 3 on j=Z-1) share stimulus.
module tb_boundary_cardinality_scanner;

  localparam int X   = 3;
  localparam int Z   = 3;
  localparam int R   = 3;
  localparam int PUC = X * Z * R;
  localparam int AW  = 5;
  localparam int ND  = 4;
  localparam int EXP_DONE [ND] = '{8, 12, 6, 6};
  localparam int DUT_BT   [ND] = '{0, 0, 0, 1};
`ifdef BOUNDARY_CARDINALITY_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                go = 1'b0;
  logic [PUC-1:0]      touch = '0;
  logic [PUC-1:0]      odd = '0;
  logic [AW*PUC-1:0]   roots = '0;
  logic [ND-1:0]       busy_v, done_v, fc_v, err_v;
  logic [ND-1:0][AW:0] cnt_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  boundary_cardinality_scanner #(.CODE_DISTANCE_X(X), .CODE_DISTANCE_Z(Z), .LANES(2), .BOUNDARY_TYPE(0)) u_l2 (
    .clk(clk), .reset(reset), .go(go), .is_touching_boundaries(touch), .is_odd_cardinalities(odd),
    .roots(roots), .busy(busy_v[0]), .done(done_v[0]), .final_cardinality(fc_v[0]),
    .odd_root_count(cnt_v[0]), .root_error(err_v[0]));
  boundary_cardinality_scanner #(.CODE_DISTANCE_X(X), .CODE_DISTANCE_Z(Z), .LANES(1), .BOUNDARY_TYPE(0)) u_l1 (
    .clk(clk), .reset(reset), .go(go), .is_touching_boundaries(touch), .is_odd_cardinalities(odd),
    .roots(roots), .busy(busy_v[1]), .done(done_v[1]), .final_cardinality(fc_v[1]),
    .odd_root_count(cnt_v[1]), .root_error(err_v[1]));
  boundary_cardinality_scanner #(.CODE_DISTANCE_X(X), .CODE_DISTANCE_Z(Z), .LANES(4), .BOUNDARY_TYPE(0)) u_l4 (
    .clk(clk), .reset(reset), .go(go), .is_touching_boundaries(touch), .is_odd_cardinalities(odd),
    .roots(roots), .busy(busy_v[2]), .done(done_v[2]), .final_cardinality(fc_v[2]),
    .odd_root_count(cnt_v[2]), .root_error(err_v[2]));
  boundary_cardinality_scanner #(.CODE_DISTANCE_X(X), .CODE_DISTANCE_Z(Z), .LANES(3), .BOUNDARY_TYPE(1)) u_b1 (
    .clk(clk), .reset(reset), .go(go), .is_touching_boundaries(touch), .is_odd_cardinalities(odd),
    .roots(roots), .busy(busy_v[3]), .done(done_v[3]), .final_cardinality(fc_v[3]),
    .odd_root_count(cnt_v[3]), .root_error(err_v[3]));

  typedef struct {
    logic [PUC-1:0]    touch;
    logic [PUC-1:0]    odd;
    logic [AW*PUC-1:0] roots;
    bit                par;
    int                cnt;
    bit                err;
  } vec_t;

  vec_t  vecs [8];
  string vnames [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [AW*PUC-1:0] set_root(input logic [AW*PUC-1:0] v, input int p, input int val);
    logic [31:0] w;
    w = val;
    v[AW*p +: AW] = w[AW-1:0];
    return v;
  endfunction

  // Reference: walk the boundary column as a set of coordinates and collect distinct odd roots.
  task automatic model(input logic [PUC-1:0] t, input logic [PUC-1:0] o, input logic [AW*PUC-1:0] r,
                       input int bt, output bit par, output int cnt, output bit err);
    bit seen [PUC];
    int j, p, root;
    j = (bt != 0) ? Z - 1 : 0;
    par = 0; cnt = 0; err = 0;
    for (int q = 0; q < PUC; q++) seen[q] = 0;
    for (int k = 0; k < R; k++) begin
      for (int i = 0; i < X; i++) begin
        p = i * Z + j + k * Z * X;
        root = int'(r[AW*p +: AW]);
        if (t[p]) begin
          if (root >= PUC) err = 1;
          else if (o[root] && !seen[root]) begin
            seen[root] = 1;
            par = ~par;
            cnt++;
          end
        end
      end
    end
  endtask

  // One full run; a go pulse is held across the busy/DONE window to show it is never accepted there.
  task automatic run_vec(input string name, input vec_t v);
    bit par1, err1;
    int cnt1;
    int first [ND];
    int pulses [ND];
    bit busy1 [ND];
    bit busy_at_done [ND];
    bit late_busy [ND];
    bit ep, ee;
    int ec;
    touch = v.touch; odd = v.odd; roots = v.roots;
    model(v.touch, v.odd, v.roots, 1, par1, cnt1, err1);
    for (int d = 0; d < ND; d++) begin
      first[d] = 0; pulses[d] = 0; busy1[d] = 0; busy_at_done[d] = 1; late_busy[d] = 0;
    end
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk);
      if (cyc == 3) go = 1'b1;
      if (cyc == 7) go = 1'b0;
      for (int d = 0; d < ND; d++) begin
        if (cyc == 1) busy1[d] = busy_v[d];
        if (done_v[d]) begin
          pulses[d]++;
          if (first[d] == 0) begin
            first[d] = cyc;
            busy_at_done[d] = busy_v[d];
          end
        end else if (first[d] != 0 && busy_v[d]) begin
          late_busy[d] = 1;
        end
      end
    end
    for (int d = 0; d < ND; d++) begin
      ep = (DUT_BT[d] != 0) ? par1 : v.par;
      ec = (DUT_BT[d] != 0) ? cnt1 : v.cnt;
      ee = (DUT_BT[d] != 0) ? err1 : v.err;
      check($sformatf("%s/u%0d done_cycle", name, d), first[d], EXP_DONE[d]);
      check($sformatf("%s/u%0d done_pulses", name, d), pulses[d], 1);
      check($sformatf("%s/u%0d busy_start", name, d), int'(busy1[d]), 1);
      check($sformatf("%s/u%0d busy_at_done", name, d), int'(busy_at_done[d]), 0);
      check($sformatf("%s/u%0d busy_after_done", name, d), int'(late_busy[d]), 0);
      check($sformatf("%s/u%0d final_cardinality", name, d), int'(fc_v[d]), int'(ep));
      check($sformatf("%s/u%0d odd_root_count", name, d), int'(cnt_v[d]), CNT_EN ? ec : 0);
      check($sformatf("%s/u%0d root_error", name, d), int'(err_v[d]), int'(ee));
    end
  endtask

  initial begin
    vec_t rv;
    bit   any_act;

    // Directed vectors; boundary j=0 PUs in visiting order are 0,3,6,9,12,15,18,21,24.
    for (int n = 0; n < 8; n++) begin
      vecs[n].touch = '0; vecs[n].odd = '0; vecs[n].roots = '0;
      vecs[n].par = 0; vecs[n].cnt = 0; vecs[n].err = 0;
    end
    vnames[0] = "all_zero";
    vnames[1] = "shared_root_0_9";
    vecs[1].touch[0] = 1; vecs[1].touch[9] = 1; vecs[1].odd[4] = 1;
    vecs[1].roots = set_root(set_root('0, 0, 4), 9, 4);
    vecs[1].par = 1; vecs[1].cnt = 1;
    vnames[2] = "three_odd_roots";
    vecs[2].touch[0] = 1; vecs[2].touch[3] = 1; vecs[2].touch[6] = 1;
    vecs[2].odd[1] = 1; vecs[2].odd[4] = 1; vecs[2].odd[7] = 1;
    vecs[2].roots = set_root(set_root(set_root('0, 0, 1), 3, 4), 6, 7);
    vecs[2].par = 1; vecs[2].cnt = 3;
    vnames[3] = "one_even_root";
    vecs[3] = vecs[2];
    vecs[3].odd[7] = 0;
    vecs[3].par = 0; vecs[3].cnt = 2;
    vnames[4] = "root_pucount_plus1";
    vecs[4].touch[0] = 1; vecs[4].touch[3] = 1; vecs[4].odd[4] = 1;
    vecs[4].roots = set_root(set_root('0, 0, 4), 3, PUC + 1);
    vecs[4].par = 1; vecs[4].cnt = 1; vecs[4].err = 1;
    vnames[5] = "same_cycle_lanes";
    vecs[5].touch[0] = 1; vecs[5].touch[3] = 1; vecs[5].odd[5] = 1;
    vecs[5].roots = set_root(set_root('0, 0, 5), 3, 5);
    vecs[5].par = 1; vecs[5].cnt = 1;
    vnames[6] = "not_touching";
    vecs[6].odd[4] = 1;
    vecs[6].roots = set_root('0, 0, 4);
    vnames[7] = "root_eq_pucount";
    vecs[7].touch[6] = 1; vecs[7].odd[0] = 1;
    vecs[7].roots = set_root('0, 6, PUC);
    vecs[7].err = 1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_flags", int'(busy_v | done_v | fc_v | err_v), 0);
    check("reset_count", int'(cnt_v != '0), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_release", int'(busy_v | done_v), 0);

    for (int n = 0; n < 8; n++) run_vec(vnames[n], vecs[n]);

    // Mid-scan reset after a run that left nonzero results.
    run_vec("pre_reset", vecs[2]);
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_reset", int'(busy_v), 4'hF);
    reset = 1'b1;
    #1;
    check("reset_mid_busy_done", int'(busy_v | done_v), 0);
    check("reset_mid_results", int'(fc_v | err_v), 0);
    check("reset_mid_count", int'(cnt_v != '0), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    any_act = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ((busy_v | done_v) != '0) any_act = 1;
    end
    check("no_done_after_reset", int'(any_act), 0);
    run_vec("after_reset", vecs[1]);

    // Random runs against the reference; out-of-range roots only on touching PUs.
    for (int n = 0; n < 20; n++) begin
      for (int p = 0; p < PUC; p++) begin
        rv.touch[p] = ($urandom_range(0, 2) == 0);
        rv.odd[p]   = $urandom_range(0, 1);
        if (rv.touch[p] && $urandom_range(0, 7) == 0)
          rv.roots = set_root(rv.roots, p, $urandom_range(PUC, 31));
        else
          rv.roots = set_root(rv.roots, p, (n % 2 == 0) ? $urandom_range(0, 8) : $urandom_range(0, PUC - 1));
      end
      model(rv.touch, rv.odd, rv.roots, 0, rv.par, rv.cnt, rv.err);
      run_vec($sformatf("rand%0d", n), rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boundary_cardinality_scanner.md
BOUNDARY_CARDINALITY_SCANNER -- requirements
Module: boundary_cardinality_scanner

Interface
REQ-001 SHALL have parameter CODE_DISTANCE_X, default 4: lattice size in i.
REQ-002 SHALL have parameter CODE_DISTANCE_Z, default 12: lattice size in j.
REQ-003 SHALL have parameter LANES, default 2: boundary PUs examined per cycle (1..BPC).
REQ-004 SHALL have parameter BOUNDARY_TYPE, default 0: 0 = boundary column j=0, 1 = boundary column j=CODE_DISTANCE_Z-1.
REQ-005 SHALL derive ROUNDS = max(X,Z), PU_COUNT = X*Z*ROUNDS, BPC = X*ROUNDS, AW = $clog2(PU_COUNT), linear index = i*Z + j + k*Z*X.
REQ-006 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port go  input  1  start request, accepted only in IDLE.
REQ-009 SHALL have port is_touching_boundaries  input  PU_COUNT  per-PU boundary-touch flag.
REQ-010 SHALL have port is_odd_cardinalities  input  PU_COUNT  per-PU odd-cluster flag, meaningful at roots.
REQ-011 SHALL have port roots  input  AW*PU_COUNT  per-PU root as linear index, PU p at bits [AW*p +: AW].
REQ-012 SHALL have port busy  output  1  high from go acceptance until done.
REQ-013 SHALL have port done  output  1  single-cycle completion pulse.
REQ-014 SHALL have port final_cardinality  output  1  parity of distinct odd roots reached from the boundary.
REQ-015 SHALL have port odd_root_count  output  AW+1  number of distinct odd roots reached.
REQ-016 SHALL have port root_error  output  1  sticky flag: a selected root index was >= PU_COUNT.

Function
REQ-017 SHALL implement states IDLE, SCAN, DRAIN, DONE: IDLE->SCAN on go; SCAN->DRAIN after the last lane group; DRAIN->DONE after 2 cycles; DONE->IDLE unconditionally.
REQ-018 SHALL visit boundary PUs in order i fastest (0..X-1), then k (0..ROUNDS-1), LANES per cycle; the final group of ceil(BPC/LANES) masks lanes beyond BPC.
REQ-019 SHALL use a 2-stage pipeline: stage 1 registers lane PU indices, stage 2 reads roots and flags and updates a PU_COUNT-bit visited bitmap.
REQ-020 SHALL, for a lane whose PU touches the boundary and whose root is unvisited and odd, mark the root visited, toggle the parity and increment the count.
REQ-021 SHALL count a root at most once per run, including when several lanes hit it in the same cycle (lowest lane wins).
REQ-022 SHALL ignore lanes whose root is >= PU_COUNT and set root_error.
REQ-023 SHALL clear the bitmap, parity, count and root_error on go acceptance.
REQ-024 SHALL assert done exactly ceil(BPC/LANES)+3 cycles after the go-accept edge, and deassert busy in the same cycle.
REQ-025 SHALL hold final_cardinality, odd_root_count and root_error stable from done until the next go acceptance.
REQ-026 SHALL ignore go while busy; go asserted in the DONE cycle SHALL NOT be accepted.
REQ-027 Upstream SHALL keep all input vectors stable while busy; the block does not sample them outside stage 2.

Reset
REQ-028 SHALL, on reset assertion at any time including mid-scan, enter IDLE immediately and clear busy, done, final_cardinality, odd_root_count, root_error and the bitmap to 0.
REQ-029 SHALL drive all outputs to 0 while reset is high, and require a fresh go after reset release.

Configuration
REQ-030 SHALL gate the count logic with macro BOUNDARY_CARDINALITY_COUNT_EN: when defined, odd_root_count is as above; when undefined, no counter is built, odd_root_count is tied to 0, and parity/done timing is unchanged.

Verification
REQ-031 X=3, Z=3, LANES=2, all flags 0, go -> done 8 cycles after the accept edge, final_cardinality=0, count=0.
REQ-032 Same config, boundary PUs 0 and 9 touching, both rooted at PU 4, is_odd[4]=1 -> final_cardinality=1, count=1.
REQ-033 Same config, PUs 0,3,6 rooted at distinct odd roots 1,4,7 -> final_cardinality=1, count=3; with PU 6 root even -> parity 0, count 2.
REQ-034 Reset pulsed 3 cycles after go -> busy, done and outputs 0 immediately; no done follows; a new go completes normally.
REQ-035 Root of a touching PU set to PU_COUNT+1 -> root_error=1, root ignored in parity and count; go pulsed while busy has no effect on timing.
REQ-036 LANES=1 versus LANES=4 on identical random inputs -> identical final_cardinality, count and root_error; done at BPC+3 and ceil(BPC/4)+3 cycles respectively.
